dmem_lsu: RTL and testbench

Load/store unit that consumes the `MemRead`/`MemWrite` strobes from the main control decoder and carries out the access on a single-outstanding req/ack data-memory bus. It stalls the core until the bus completes, drives byte lanes from `funct3`, and returns sign- or zero-extended load data. It sits between the EX-stage ALU result (the address) and the data memory.

---
 rtl/dmem_lsu_if.sv | 26 ++
 rtl/dmem_lsu.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: single-outstanding data-memory bus between the load/store unit
// (master) and the data memory (slave).
//
// Handshake: the master raises bus_req together with bus_we/bus_addr/bus_be/
// bus_wdata and holds all of them constant until the slave answers with a
// one-cycle bus_ack. bus_rdata is valid in that same ack cycle. Only one
// access is ever outstanding; bus_req drops in the cycle after the ack.
interface dmem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit. Takes MemRead/MemWrite from the control decoder,
// performs one access on the req/ack bus, stalls the core until it finishes
// and returns sign/zero-extended load data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/HU/W accesses
// become errors instead of being silently naturally aligned).
// dbg_state exposes the FSM state (0 IDLE, 1 REQ, 2 DONE).
module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              err,
  dmem_lsu_if.master        bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYC);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic        err_q, err_d;

  logic        req_legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ext_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [9:0]  cnt_inc;

  assign cnt_inc = cnt_q + 10'd1;

  // Classify the request presented in IDLE as legal or illegal.
  always_comb begin
    req_legal = 1'b1;
    if (mem_read && mem_write) begin
      req_legal = 1'b0;
    end else if (mem_read) begin
      req_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      req_legal = funct3 inside {3'b000, 3'b001, 3'b010};
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (funct3[1:0] == 2'b01 && addr[0]) begin
      req_legal = 1'b0;
    end
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
      req_legal = 1'b0;
    end
`endif
  end

  // Byte enables and lane-replicated store data for a new request.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it.
  always_comb begin
    byte_sel = bus.bus_rdata[7:0];
    half_sel = lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    ext_data = bus.bus_rdata;
    case (lo_q)
      2'b00:   byte_sel = bus.bus_rdata[7:0];
      2'b01:   byte_sel = bus.bus_rdata[15:8];
      2'b10:   byte_sel = bus.bus_rdata[23:16];
      default: byte_sel = bus.bus_rdata[31:24];
    endcase
    case (f3_q[1:0])
      2'b00:   ext_data = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   ext_data = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: ext_data = bus.bus_rdata;
    endcase
  end

  // Next-state logic: IDLE accepts or rejects, REQ waits for ack or timeout,
  // DONE retires for exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = 10'd0;
        err_d   = 1'b0;
        ldata_d = 32'd0;
        if (mem_read || mem_write) begin
          if (!req_legal) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            waddr_d = addr[31:2];
            lo_d    = addr[1:0];
            f3_d    = funct3;
            we_d    = mem_write;
            be_d    = be_new;
            wdata_d = wdata_new;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_ack) begin
          ldata_d = we_q ? 32'd0 : ext_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_inc == TO_LIM) begin
          ldata_d = 32'd0;
          err_d   = 1'b1;
          cnt_d   = cnt_inc;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 10'd0;
      waddr_q <= 30'd0;
      lo_q    <= 2'd0;
      f3_q    <= 3'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      ldata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  // Stall is gated by rst_n so every output reads 0 while reset is held,
  // even if the decoder strobes stay asserted.
  assign stall = rst_n & (((state_q == S_IDLE) & (mem_read | mem_write)) |
                          (state_q == S_REQ));
  assign load_valid = (state_q == S_DONE) & ~err_q & ~we_q;
  assign err        = (state_q == S_DONE) & err_q;
  assign load_data  = load_valid ? ldata_q : 32'd0;

  assign bus.bus_req   = (state_q == S_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {waddr_q, 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and randomized checks of dmem_lsu against a
// transaction-level model. The driver turns each memory instruction into the
// cycle-by-cycle output picture the unit must show; a compare process checks
// the DUT against that picture on every cycle.
module tb_dmem_lsu;

  localparam int TO = 4;
  localparam int W  = 105;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        err;
  logic [1:0]  dbg_state;

  dmem_lsu_if bus_if ();

  dmem_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .err        (err),
    .bus        (bus_if),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fails     = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];

  // observed per-cycle and per-op values
  logic        obs_stall, obs_lv, obs_err, obs_req;
  logic [31:0] obs_ld;
  int          op_stall, op_req;
  logic        op_lv, op_err;
  logic [31:0] op_ld;

  function automatic logic [W-1:0] pk(logic st, logic lv, logic er, logic [31:0] ld,
                                      logic rq, logic we, logic [31:0] ba,
                                      logic [3:0] be, logic [31:0] wd);
    return {st, lv, er, ld, rq, we, ba, be, wd};
  endfunction

  // Compare everything except fields that carry no meaning this cycle.
  function automatic logic [W-1:0] mk(logic lv, logic er, logic rq, logic wd_used);
    logic [W-1:0] m;
    m = '1;
    if (!(lv || er)) m[101:70] = '0;
    if (!rq) m[68:0] = '0;
    else if (!wd_used) m[31:0] = '0;
    return m;
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e, m, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      a = pk(stall, load_valid, err, load_data, bus_if.bus_req, bus_if.bus_we,
             bus_if.bus_addr, bus_if.bus_be, bus_if.bus_wdata);
      tests_run++;
      if ((a & m) !== (e & m)) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got %h expected %h mask %h", $time, a, e, m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
    if (rd && wr) return 1'b0;
    if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b0;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b0;
`else
    if (a === 32'bx) return 1'b1;
`endif
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    if (f3[1:0] == 2'b00) return 4'(1 << a[1:0]);
    if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] d);
    if (f3[1:0] == 2'b00) return {4{d[7:0]}};
    if (f3[1:0] == 2'b01) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    logic [31:0] sh;
    longint v;
    if (f3[1:0] == 2'b00) begin
      sh = rd >> (8 * a[1:0]);
      v = longint'(sh[7:0]);
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'b01) begin
      sh = rd >> (16 * a[1]);
      v = longint'(sh[15:0]);
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return 32'(v);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [W-1:0] e, input logic [W-1:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
    @(negedge clk);
    obs_stall = stall;
    obs_lv    = load_valid;
    obs_err   = err;
    obs_ld    = load_data;
    obs_req   = bus_if.bus_req;
    @(posedge clk);
    #1;
  endtask

  task automatic tally();
    op_stall += int'(obs_stall);
    op_req   += int'(obs_req);
    if (obs_lv) op_lv = 1'b1;
    if (obs_err) op_err = 1'b1;
    if (obs_lv || obs_err) op_ld = obs_ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = $urandom;
      step(pk(0, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0));
    end
  endtask

  // One memory instruction, held on the decoder strobes until it retires.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdt, input int waits, input bit never_ack);
    bit ok, acked;
    int n_req;
    logic [31:0] exp_ld;
    op_stall = 0; op_req = 0; op_lv = 1'b0; op_err = 1'b0; op_ld = 32'd0;
    ok = m_legal(rd, wr, f3, a);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = $urandom;
    step(pk(1, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0));
    tally();
    if (!ok) begin
      step(pk(0, 0, 1, 0, 0, 0, 0, 0, 0), mk(0, 1, 0, 0));
      tally();
    end else begin
      acked = !never_ack && (waits + 1 <= TO);
      n_req = acked ? waits + 1 : TO;
      for (int k = 1; k <= n_req; k++) begin
        bus_if.bus_ack = acked && (k == n_req);
        bus_if.bus_rdata = (acked && k == n_req) ? rdt : $urandom;
        step(pk(1, 0, 0, 0, 1, wr, {a[31:2], 2'b00}, m_be(f3, a), m_wd(f3, wd)),
             mk(0, 0, 1, wr));
        tally();
      end
      bus_if.bus_ack = 1'b0;
      exp_ld = (rd && acked) ? m_load(f3, a, rdt) : 32'd0;
      step(pk(0, rd && acked, !acked, exp_ld, 0, 0, 0, 0, 0), mk(rd && acked, !acked, 0, 0));
      tally();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] f3;
    logic rd, wr;
    int r;

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
    @(posedge clk);
    #1;
    // reset state: every output zero
    step(pk(0, 0, 0, 0, 0, 0, 0, 0, 0), {W{1'b1}});
    step(pk(0, 0, 0, 0, 0, 0, 0, 0, 0), {W{1'b1}});
    rst_n = 1'b1;
    idle(2);

    // model pins
    chk("model_lb",  m_load(3'b000, 32'h103, 32'h80FFFFFF), 32'hFFFFFF80);
    chk("model_lbu", m_load(3'b100, 32'h103, 32'h80FFFFFF), 32'h00000080);
    chk("model_lh",  m_load(3'b001, 32'h2, 32'h8001_1234), 32'hFFFF8001);
    chk("model_lhu", m_load(3'b101, 32'h0, 32'h1234_F00D), 32'h0000F00D);
    chk("model_sh_wd", m_wd(3'b001, 32'h1234ABCD), 32'hABCDABCD);
    chk("model_sh_be", 32'(m_be(3'b001, 32'h202)), 32'hC);

    // LW 0x100, ack in first REQ cycle
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lw_data", op_ld, 32'hDEADBEEF);
    chk("lw_stall", 32'(op_stall), 32'd2);
    chk("lw_valid", 32'(op_lv), 32'd1);
    idle(1);

    // LB / LBU at 0x103, back to back
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
    chk("lb_data", op_ld, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
    chk("lbu_data", op_ld, 32'h00000080);
    idle(1);

    // SH 0x202 with three wait cycles
    do_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0);
    chk("sh_stall", 32'(op_stall), 32'd5);
    chk("sh_no_valid", 32'(op_lv), 32'd0);
    chk("sh_no_err", 32'(op_err), 32'd0);
    idle(1);

    // LW at misaligned 0x102
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(op_err), 32'd1);
    chk("lw_mis_noreq", 32'(op_req), 32'd0);
    chk("lw_mis_stall", 32'(op_stall), 32'd1);
`else
    chk("lw_mis_data", op_ld, 32'hCAFEF00D);
    chk("lw_mis_stall", 32'(op_stall), 32'd2);
`endif
    idle(1);

    // timeout: ack never comes
    do_op(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1);
    chk("to_req_cycles", 32'(op_req), 32'(TO));
    chk("to_err", 32'(op_err), 32'd1);
    chk("to_data", op_ld, 32'd0);
    chk("to_no_valid", 32'(op_lv), 32'd0);
    // ack on the last allowed REQ cycle wins over the timeout
    do_op(1, 0, 3'b010, 32'h404, 32'h0, 32'h5A5A1234, TO - 1, 0);
    chk("late_ack_err", 32'(op_err), 32'd0);
    chk("late_ack_data", op_ld, 32'h5A5A1234);
    idle(1);

    // illegal requests: both strobes, bad load code, bad store code
    do_op(1, 1, 3'b010, 32'h10, 32'h0, 32'h0, 0, 0);
    chk("both_err", 32'(op_err), 32'd1);
    chk("both_noreq", 32'(op_req), 32'd0);
    do_op(1, 0, 3'b011, 32'h10, 32'h0, 32'h0, 0, 0);
    chk("ld011_err", 32'(op_err), 32'd1);
    do_op(0, 1, 3'b100, 32'h10, 32'h0, 32'h0, 0, 0);
    chk("st100_err", 32'(op_err), 32'd1);
    idle(1);

    // reset during the second REQ cycle
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
    bus_if.bus_ack = 1'b0;
    step(pk(1, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0));
    step(pk(1, 0, 0, 0, 1, 0, 32'h300, 4'hF, 0), mk(0, 0, 1, 0));
    rst_n = 1'b0;
    step(pk(0, 0, 0, 0, 0, 0, 0, 0, 0), {W{1'b1}});
    mem_read = 1'b0;
    step(pk(0, 0, 0, 0, 0, 0, 0, 0, 0), {W{1'b1}});
    rst_n = 1'b1;
    idle(2);
    do_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h13572468, 1, 0);
    chk("post_rst_data", op_ld, 32'h13572468);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      rd = (r <= 5);
      wr = (r == 0) || (r >= 6);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd && !wr) begin
        r = $urandom_range(0, 4);
        f3 = (r == 3) ? 3'b100 : (r == 4) ? 3'b101 : 3'(r);
      end else f3 = 3'($urandom_range(0, 2));
      do_op(rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, TO), 1'b0);
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
